// File: rtl/fm_base_streamer_if.sv
// Packed-base word stream into the FM buffer streamer.
// Master drives words; slave (streamer) returns in_ready.
interface fm_base_streamer_if #(
    parameter int WORD_BITS = 16
);
    logic [WORD_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/fm_base_streamer.sv
// Write-side driver for the FM ping-pong fragment buffer: word FIFO,
// base serializer and swap control. Option: FM_STREAMER_STATS_EN.
module fm_base_streamer #(
    parameter int DATA_BITS  = 2,
    parameter int WORD_BITS  = 16,
    parameter int BUF_BASES  = 32,
    parameter int FIFO_WORDS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fm_base_streamer_if.slave    src,
    output logic [DATA_BITS-1:0] fm_wdata,
    output logic                 fm_chg_idx,
    input  logic                 fm_wait,
    input  logic                 rd_done,
    output logic                 rd_buf_valid,
    output logic                 rd_buf_last,
    output logic                 err
`ifdef FM_STREAMER_STATS_EN
    ,
    output logic [15:0]          stat_bufs,
    output logic [15:0]          stat_stall
`endif
);
    localparam int BPW       = WORD_BITS / DATA_BITS;
    localparam int BUF_WORDS = BUF_BASES / BPW;
    localparam int CW        = $clog2(BUF_BASES);
    localparam int BW        = $clog2(BPW);
    localparam int PW        = $clog2(FIFO_WORDS);
    localparam int NW        = PW + 1;

    typedef enum logic [1:0] {PRIME, FILL, HOLD} state_t;

    state_t               state;
    logic [CW-1:0]        base_cnt;
    logic                 wr_valid;
    logic                 wr_last;
    logic                 pad;
    logic [DATA_BITS-1:0] hold_q;

    logic [WORD_BITS:0]   mem [FIFO_WORDS];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [NW-1:0]        count;
    logic [NW-1:0]        last_cnt;

    logic [WORD_BITS-1:0] head_data;
    logic                 head_last;
    logic [DATA_BITS-1:0] head_base;
    logic [BW-1:0]        sel;
    logic                 live;
    logic                 push;
    logic                 pop;
    logic                 data_rdy;
    logic                 rd_free;
    logic                 swap;

    assign head_data = mem[rd_ptr][WORD_BITS-1:0];
    assign head_last = mem[rd_ptr][WORD_BITS];
    assign sel       = base_cnt[BW-1:0];
    assign head_base = head_data[DATA_BITS*int'(sel) +: DATA_BITS];
    assign live      = wr_valid & ~pad;

    assign src.in_ready = (count != NW'(FIFO_WORDS));
    assign push         = src.in_valid & src.in_ready;

    // The last word of a half leaves the FIFO one base early; its final
    // base is parked in hold_q and replayed throughout HOLD.
    assign pop = (state == FILL) & live &
                 ((&sel) | (base_cnt == CW'(BUF_BASES-2)));

    assign data_rdy = (count >= NW'(BUF_WORDS)) | (last_cnt != '0);
    assign rd_free  = ~rd_buf_valid | rd_done;
    assign swap     = (state == HOLD) & (wr_valid ? rd_free : data_rdy);
    assign fm_chg_idx = swap;

    // Base currently presented to the FM write port.
    always_comb begin
        fm_wdata = '0;
        if (state == FILL && live) begin
            fm_wdata = head_base;
        end else if (state == HOLD) begin
            fm_wdata = hold_q;
        end
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {src.in_last, src.in_data};
        end
    end

    // FIFO pointers, occupancy and count of last-marked entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count + NW'(push) - NW'(pop);
            last_cnt <= last_cnt + NW'(push & src.in_last)
                                 - NW'(pop & head_last);
        end
    end

    // Prime/fill/hold sequencing, swap bookkeeping and mirror check.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PRIME;
            base_cnt     <= '0;
            wr_valid     <= 1'b0;
            wr_last      <= 1'b0;
            pad          <= 1'b0;
            hold_q       <= '0;
            rd_buf_valid <= 1'b0;
            rd_buf_last  <= 1'b0;
            err          <= 1'b0;
        end else begin
            if ((state == HOLD) ? (~fm_wait & ~swap) : fm_wait) begin
                err <= 1'b1;
            end
            if (rd_done && !swap) begin
                rd_buf_valid <= 1'b0;
                rd_buf_last  <= 1'b0;
            end
            unique case (state)
                PRIME, FILL: begin
                    base_cnt <= base_cnt + 1'b1;
                    if (pop && head_last) begin
                        pad     <= 1'b1;
                        wr_last <= 1'b1;
                    end
                    if (base_cnt == CW'(BUF_BASES-2)) begin
                        state  <= HOLD;
                        hold_q <= (state == FILL && live) ?
                                  head_data[WORD_BITS-1 -: DATA_BITS] : '0;
                    end
                end
                HOLD: begin
                    if (swap) begin
                        state        <= FILL;
                        base_cnt     <= '0;
                        rd_buf_valid <= wr_valid;
                        rd_buf_last  <= wr_last;
                        wr_valid     <= data_rdy;
                        wr_last      <= 1'b0;
                        pad          <= 1'b0;
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

`ifdef FM_STREAMER_STATS_EN
    // Saturating counts of handed-off halves and reader-caused stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bufs  <= '0;
            stat_stall <= '0;
        end else begin
            if (swap && wr_valid && !(&stat_bufs)) begin
                stat_bufs <= stat_bufs + 1'b1;
            end
            if (state == HOLD && wr_valid && !rd_free && !(&stat_stall)) begin
                stat_stall <= stat_stall + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fm_base_streamer.sv
// Directed bench for fm_base_streamer with a small FM buffer model
// that captures each written half for comparison.
module tb_fm_base_streamer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] fm_wdata;
    logic       fm_chg_idx;
    logic       fm_wait;
    logic       rd_done = 1'b0;
    logic       rd_buf_valid;
    logic       rd_buf_last;
    logic       err;
`ifdef FM_STREAMER_STATS_EN
    logic [15:0] stat_bufs;
    logic [15:0] stat_stall;
`endif

    fm_base_streamer_if #(.WORD_BITS(16)) bus ();

    fm_base_streamer dut (
        .clk          (clk),
        .rst          (rst),
        .src          (bus),
        .fm_wdata     (fm_wdata),
        .fm_chg_idx   (fm_chg_idx),
        .fm_wait      (fm_wait),
        .rd_done      (rd_done),
        .rd_buf_valid (rd_buf_valid),
        .rd_buf_last  (rd_buf_last),
        .err          (err)
`ifdef FM_STREAMER_STATS_EN
        ,
        .stat_bufs    (stat_bufs),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         pushed = 0;
    int         feed_n = 0;
    bit         feed = 1'b0;
    logic       force_lo = 1'b0;
    logic [4:0] fm_addr;
    logic [1:0] wbuf [32];
    logic [1:0] rbuf [32];
    logic [16:0] exp_q [$];

    assign fm_wait = (fm_addr == 5'd31) && !fm_chg_idx && !force_lo;

    // FM buffer model: write every cycle, hold at 31, swap halves.
    always @(posedge clk) begin
        if (rst) begin
            fm_addr <= 5'd0;
        end else begin
            wbuf[fm_addr] <= fm_wdata;
            if (fm_chg_idx) begin
                for (int i = 0; i < 31; i++) rbuf[i] <= wbuf[i];
                rbuf[31] <= fm_wdata;
                fm_addr  <= 5'd0;
            end else if (fm_addr != 5'd31) begin
                fm_addr <= fm_addr + 5'd1;
            end
        end
    end

    // Accepted word count drives the streaming feeder.
    always @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) pushed <= pushed + 1;
    end

    function automatic logic [15:0] wordf(int k);
        return 16'(k * 40503 + 4660);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic feed_drive();
        if (feed) begin
            bus.in_valid = (pushed < feed_n);
            bus.in_data  = wordf(pushed);
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        feed_drive();
        #1;
    endtask

    task automatic wait_hold(input string tag);
        int n = 0;
        while (fm_addr != 5'd31 && n < 80) begin
            step();
            n++;
        end
        chk(tag, 32'(fm_addr), 32'd31);
    endtask

    task automatic read_half(input string tag);
        int          bad = 0;
        bit          pd = 1'b0;
        logic [16:0] w;
        for (int i = 0; i < 4; i++) begin
            w = '0;
            if (!pd && exp_q.size() != 0) w = exp_q.pop_front();
            for (int b = 0; b < 8; b++) begin
                if (rbuf[i*8+b] !== w[2*b +: 2]) bad++;
            end
            if (w[16]) pd = 1'b1;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int bad;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // Reset and priming pass
        step();
        step();
        rst = 1'b0;
        chk("rst_wdata", 32'(fm_wdata), 0);
        chk("rst_chg", 32'(fm_chg_idx), 0);
        chk("rst_rbv", 32'(rd_buf_valid), 0);
        chk("rst_rbl", 32'(rd_buf_last), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(bus.in_ready), 1);
        bad = 0;
        for (int i = 0; i < 31; i++) begin
            if (fm_wdata != 2'd0 || fm_chg_idx) bad++;
            step();
        end
        chk("prime_zero", 32'(bad), 0);
        chk("prime_wait", 32'(fm_wait), 1);
        chk("prime_chg", 32'(fm_chg_idx), 0);
        chk("prime_err", 32'(err), 0);

        // Four words into idle HOLD
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h1B1B;
            bus.in_last  = 1'b0;
            exp_q.push_back({1'b0, 16'h1B1B});
            step();
        end
        bus.in_valid = 1'b0;
        chk("t2_swap", 32'(fm_chg_idx), 1);
        bad = 0;
        for (int i = 0; i < 31; i++) begin
            step();
            if (fm_wdata != 2'(3 - i % 4) || fm_chg_idx) bad++;
        end
        chk("t2_bases", 32'(bad), 0);
        step();
        chk("t2_b31", 32'(fm_wdata), 0);
        chk("t2_swap2", 32'(fm_chg_idx), 1);
        step();
        chk("t2_rbv", 32'(rd_buf_valid), 1);
        chk("t2_rbl", 32'(rd_buf_last), 0);
        read_half("t2_half");

        // Streaming with a stalled reader
        feed   = 1'b1;
        feed_n = pushed + 16;
        for (int k = pushed; k < feed_n; k++) exp_q.push_back({1'b0, wordf(k)});
        feed_drive();
        wait_hold("t3_hold0");
        step();
        wait_hold("t3_hold1");
        step();
        chk("t3_rbv", 32'(rd_buf_valid), 1);
        read_half("t3_half0");
        wait_hold("t3_hold2");
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (fm_chg_idx) bad++;
            step();
        end
        chk("t3_nochg", 32'(bad), 0);
        chk("t3_full", 32'(bus.in_ready), 0);
        rd_done = 1'b1;
        #1;
        chk("t3_swap", 32'(fm_chg_idx), 1);
        step();
        rd_done = 1'b0;
        chk("t3_rbv2", 32'(rd_buf_valid), 1);
        read_half("t3_half1");
        chk("t3_err", 32'(err), 0);
`ifdef FM_STREAMER_STATS_EN
        chk("t3_stall", 32'(stat_stall), 100);
        chk("t3_bufs", 32'(stat_bufs), 3);
`endif

        // Reset mid-fill at base 12
        feed = 1'b0;
        bus.in_valid = 1'b0;
        repeat (12) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("t6_chg", 32'(fm_chg_idx), 0);
        chk("t6_rbv", 32'(rd_buf_valid), 0);
        chk("t6_ready", 32'(bus.in_ready), 1);
        chk("t6_wdata", 32'(fm_wdata), 0);
        repeat (40) step();
        chk("t6_align", 32'(err), 0);

        // Two words, second one last
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hE4E4;
        bus.in_last  = 1'b0;
        exp_q.push_back({1'b0, 16'hE4E4});
        step();
        bus.in_data  = 16'h5A5A;
        bus.in_last  = 1'b1;
        exp_q.push_back({1'b1, 16'h5A5A});
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("t4_swap", 32'(fm_chg_idx), 1);
        step();
        step();
        chk("t4_base1", 32'(fm_wdata), 1);
        wait_hold("t4_hold");
        step();
        chk("t4_rbv", 32'(rd_buf_valid), 1);
        chk("t4_rbl", 32'(rd_buf_last), 1);
        read_half("t4_half");

        // Mirror disagreement sets sticky err
        wait_hold("t5_hold");
        chk("t5_pre", 32'(err), 0);
        force_lo = 1'b1;
        #1;
        step();
        force_lo = 1'b0;
        chk("t5_err", 32'(err), 1);
        repeat (5) step();
        chk("t5_sticky", 32'(err), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_clr", 32'(err), 0);
`ifdef FM_STREAMER_STATS_EN
        chk("t5_stat", 32'(stat_bufs), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
